// File: rtl/drac_pkg.sv
// Shared definitions for the L1.5 request path: arbiter FSM states and the
// default requester port indices.
package drac_pkg;

   typedef enum logic [0:0] {
      L15_IDLE = 1'b0,
      L15_SEND = 1'b1
   } l15_arb_state_e;

   localparam int unsigned ICACHE = 0;
   localparam int unsigned DMISS  = 1;
   localparam int unsigned WBUF   = 2;
   localparam int unsigned UCRD   = 3;
   localparam int unsigned UCWR   = 4;

endpackage

// File: rtl/rr_find_first.sv
// Round-robin search: first set bit of req at or after ptr, wrapping N-1 -> 0.
module rr_find_first #(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scan from the farthest offset back to the pointer so the nearest hit wins
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      idx   = {W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % N;
         if (req[W'(j)]) begin
            found = 1'b1;
            idx   = W'(j);
         end else begin
            found = found;
            idx   = idx;
         end
      end
   end

endmodule

// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter from the L1 requesters to the L1.5, with per-port
// outstanding-request limits and a sticky protocol-error flag.
module l15_req_arbiter
   import drac_pkg::*;
#(
   parameter int NPorts         = 5,
   parameter int ReqWidth       = 128,
   parameter int MaxOutstanding = 2
) (
   input  logic                                    clk_i,
   input  logic                                    reset_l,
   input  logic [NPorts-1:0]                       req_valid_i,
   output logic [NPorts-1:0]                       req_ready_o,
   input  logic [NPorts*ReqWidth-1:0]              req_data_i,
   output logic                                    l15_val_o,
   output logic [ReqWidth-1:0]                     l15_data_o,
   output logic [((NPorts > 1) ? $clog2(NPorts) : 1)-1:0] l15_portid_o,
   input  logic                                    l15_header_ack_i,
   input  logic                                    rtrn_val_i,
   input  logic [((NPorts > 1) ? $clog2(NPorts) : 1)-1:0] rtrn_portid_i,
   output logic                                    err_o
);

   localparam int PW = (NPorts > 1) ? $clog2(NPorts) : 1;
   localparam int CW = $clog2(MaxOutstanding + 1);

   l15_arb_state_e    state_r;
   l15_arb_state_e    state_next_s;
   logic [PW-1:0]     rr_ptr_r;
   logic [CW-1:0]     cnt_r [NPorts];
   logic [NPorts-1:0] eligible_s;
   logic              found_s;
   logic [PW-1:0]     win_idx_s;
   logic              grant_s;
   logic              ack_s;
   logic [ReqWidth-1:0] sel_data_s;
   logic [NPorts-1:0] inc_s;
   logic [NPorts-1:0] dec_s;
   logic [NPorts-1:0] underflow_s;
   logic              err_set_s;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      if (int'(p) == NPorts - 1) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   rr_find_first #(.N(NPorts), .W(PW)) u_rr_find_first (
      .req   (eligible_s),
      .ptr   (rr_ptr_r),
      .found (found_s),
      .idx   (win_idx_s)
   );

   // Eligibility, payload select and per-port counter/error events
   always_comb begin
      eligible_s  = '0;
      sel_data_s  = '0;
      inc_s       = '0;
      dec_s       = '0;
      underflow_s = '0;
      ack_s       = (state_r == L15_SEND) && l15_header_ack_i;
      grant_s     = (state_r == L15_IDLE) && found_s;
      for (int p = 0; p < NPorts; p++) begin
         eligible_s[p]  = req_valid_i[p] && (cnt_r[p] < CW'(MaxOutstanding));
         inc_s[p]       = ack_s && (l15_portid_o == PW'(p));
         dec_s[p]       = rtrn_val_i && (rtrn_portid_i == PW'(p));
         underflow_s[p] = dec_s[p] && !inc_s[p] && (cnt_r[p] == {CW{1'b0}});
         if (win_idx_s == PW'(p)) begin
            sel_data_s = req_data_i[p*ReqWidth +: ReqWidth];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
      err_set_s = ((state_r == L15_IDLE) && l15_header_ack_i)
                | (rtrn_val_i && (int'(rtrn_portid_i) >= NPorts))
                | (|underflow_s);
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         state_r <= L15_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         L15_IDLE: begin
            if (grant_s) begin
               state_next_s = L15_SEND;
            end else begin
               state_next_s = L15_IDLE;
            end
         end
         L15_SEND: begin
            if (ack_s) begin
               state_next_s = L15_IDLE;
            end else begin
               state_next_s = L15_SEND;
            end
         end
         default: state_next_s = L15_IDLE;
      endcase
   end

   // FSM outputs; accept is held off while reset is asserted
   always_comb begin
      l15_val_o   = (state_r == L15_SEND);
      req_ready_o = '0;
      for (int p = 0; p < NPorts; p++) begin
         if (reset_l && grant_s && (win_idx_s == PW'(p))) begin
            req_ready_o[p] = 1'b1;
         end else begin
            req_ready_o[p] = 1'b0;
         end
      end
   end

   // Request capture and round-robin pointer
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         l15_data_o   <= '0;
         l15_portid_o <= '0;
         rr_ptr_r     <= '0;
      end else begin
         if (grant_s) begin
            l15_data_o   <= sel_data_s;
            l15_portid_o <= win_idx_s;
         end
         if (ack_s) begin
            rr_ptr_r <= wrap_inc(l15_portid_o);
         end
      end
   end

   // Outstanding counters: a simultaneous ack and return on one port cancel out
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         for (int p = 0; p < NPorts; p++) begin
            cnt_r[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NPorts; p++) begin
            if (inc_s[p] && !dec_s[p]) begin
               if (cnt_r[p] < CW'(MaxOutstanding)) begin
                  cnt_r[p] <= cnt_r[p] + CW'(1);
               end
            end else if (dec_s[p] && !inc_s[p]) begin
               if (cnt_r[p] != {CW{1'b0}}) begin
                  cnt_r[p] <= cnt_r[p] - CW'(1);
               end
            end
         end
      end
   end

   // Sticky protocol error
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         err_o <= 1'b0;
      end else begin
         err_o <= err_o | err_set_s;
      end
   end

endmodule
